// File: rtl/render_pkg.sv
// Shared types and constants for the playfield plot sequencer.
// Screen geometry matches the 160x120 vga_adapter.
package render_pkg;

  localparam int SCR_X_W = 8;
  localparam int SCR_Y_W = 7;
  localparam int CLR_W   = 3;

  localparam logic [CLR_W-1:0] BG_CLR   = 3'b000;
  localparam logic [CLR_W-1:0] WALL_CLR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WALL,
    ST_ERASE,
    ST_SPRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/playfield_renderer_if.sv
// Control, bitmap-read and adapter signals of the renderer.
// master = game datapath side, slave = renderer.
interface playfield_renderer_if #(
  parameter int FIELD_W = 120,
  parameter int FIELD_H = 100,
  parameter int X_W     = render_pkg::SCR_X_W,
  parameter int Y_W     = render_pkg::SCR_Y_W,
  parameter int COL_W   = render_pkg::CLR_W
);

  localparam int CX_W = $clog2(FIELD_W);
  localparam int CY_W = $clog2(FIELD_H);

  logic             start;
  logic             mode;
  logic [CX_W-1:0]  spr_x;
  logic [CY_W-1:0]  spr_y;
  logic [COL_W-1:0] spr_clr;
  logic [CX_W-1:0]  rd_col;
  logic [FIELD_H-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_clr;
  logic             vga_plot;

  modport master (
    output start, mode, spr_x, spr_y, spr_clr, rd_data,
    input  rd_col, busy, done,
    input  vga_x, vga_y, vga_clr, vga_plot
  );

  modport slave (
    input  start, mode, spr_x, spr_y, spr_clr, rd_data,
    output rd_col, busy, done,
    output vga_x, vga_y, vga_clr, vga_plot
  );

endinterface

// File: rtl/playfield_renderer_rect_scanner.sv
// Column-major walker over a W x H rectangle (dx outer, dy inner).
// dx/dy is the offset emitted at this edge; last marks the final one.
module rect_scanner #(
  parameter int W    = 4,
  parameter int H    = 6,
  parameter int DX_W = (W > 1) ? $clog2(W) : 1,
  parameter int DY_W = (H > 1) ? $clog2(H) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            step,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic            last
);

  logic [DX_W-1:0] dx_q;
  logic [DY_W-1:0] dy_q;
  logic            fin;

  assign dx  = start ? '0 : dx_q;
  assign dy  = start ? '0 : dy_q;
  assign fin = (dx == DX_W'(W - 1)) && (dy == DY_W'(H - 1));

  // advance the cursor; wraps to origin after the final offset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
      last <= 1'b0;
    end else if (start || step) begin
      last <= fin;
      if (dy == DY_W'(H - 1)) begin
        dy_q <= '0;
        dx_q <= fin ? '0 : dx + 1'b1;
      end else begin
        dy_q <= dy + 1'b1;
        dx_q <= dx;
      end
    end else begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/playfield_renderer.sv
// Plot sequencer: streams the playfield bitmap and sprite to the
// vga_adapter, one pixel per clk, with erase and edge clipping.
module playfield_renderer
  import render_pkg::*;
#(
  parameter int FIELD_W = 120,
  parameter int FIELD_H = 100,
  parameter int X_OFF   = 20,
  parameter int Y_OFF   = 10,
  parameter int SPR_W   = 4,
  parameter int SPR_H   = 6,
  parameter int X_W     = SCR_X_W,
  parameter int Y_W     = SCR_Y_W,
  parameter int COL_W   = CLR_W
) (
  input logic clk,
  input logic resetn,
  playfield_renderer_if.slave bus
);

  localparam int CX_W = $clog2(FIELD_W);
  localparam int CY_W = $clog2(FIELD_H);
  localparam int FX_W = CX_W + 1;
  localparam int FY_W = CY_W + 1;
  localparam int DX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  state_t             state;
  logic [CX_W-1:0]    col;
  logic [CY_W-1:0]    row;
  logic [FIELD_H-1:0] col_bits;
  logic [CX_W-1:0]    s_x, prev_x;
  logic [CY_W-1:0]    s_y, prev_y;
  logic [COL_W-1:0]   s_clr;
  logic               prev_valid;

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            scan_start, scan_step, scan_last;

  logic idle, accept, col_end, last_col;

  logic             use_prev;
  logic [CX_W-1:0]  bx;
  logic [CY_W-1:0]  by;
  logic [COL_W-1:0] rclr;
  logic [FX_W-1:0]  fx;
  logic [FY_W-1:0]  fy;
  logic             rect_in;

  assign idle     = (state == ST_IDLE) || (state == ST_DONE);
  assign accept   = idle && bus.start;
  assign col_end  = row == CY_W'(FIELD_H - 1);
  assign last_col = col == CX_W'(FIELD_W - 1);

  assign scan_start = (accept && bus.mode)
                   || (state == ST_WALL && col_end && last_col)
                   || (state == ST_ERASE && scan_last);
  assign scan_step  = (state == ST_ERASE || state == ST_SPRITE)
                   && !scan_last;

  rect_scanner #(
    .W    (SPR_W),
    .H    (SPR_H),
    .DX_W (DX_W),
    .DY_W (DY_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .step   (scan_step),
    .dx     (dx),
    .dy     (dy),
    .last   (scan_last)
  );

  // rectangle pixel emitted at this edge: old rect in BG or new sprite
  always_comb begin
    use_prev = idle ? prev_valid
                    : (state == ST_ERASE && !scan_last);
    bx   = idle ? bus.spr_x   : s_x;
    by   = idle ? bus.spr_y   : s_y;
    rclr = idle ? bus.spr_clr : s_clr;
    if (use_prev) begin
      bx   = prev_x;
      by   = prev_y;
      rclr = COL_W'(BG_CLR);
    end
    fx = FX_W'(bx) + FX_W'(dx);
    fy = FY_W'(by) + FY_W'(dy);
    rect_in = (fx < FX_W'(FIELD_W)) && (fy < FY_W'(FIELD_H));
  end

  // pass sequencer with registered adapter outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      col_bits     <= '0;
      s_x          <= '0;
      s_y          <= '0;
      s_clr        <= '0;
      prev_x       <= '0;
      prev_y       <= '0;
      prev_valid   <= 1'b0;
      bus.rd_col   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.vga_x    <= '0;
      bus.vga_y    <= '0;
      bus.vga_clr  <= '0;
      bus.vga_plot <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.vga_plot <= 1'b0;
      unique case (1'b1)
        idle: begin
          state <= ST_IDLE;
          if (bus.start) begin
            s_x      <= bus.spr_x;
            s_y      <= bus.spr_y;
            s_clr    <= bus.spr_clr;
            bus.busy <= 1'b1;
            if (!bus.mode) begin
              state      <= ST_FETCH;
              col        <= '0;
              bus.rd_col <= '0;
            end else begin
              state <= prev_valid ? ST_ERASE : ST_SPRITE;
            end
          end
        end
        state == ST_FETCH: state <= ST_LOAD;
        state == ST_LOAD: begin
          state        <= ST_WALL;
          row          <= '0;
          col_bits     <= bus.rd_data >> 1;
          bus.vga_plot <= 1'b1;
          bus.vga_x    <= X_W'(X_OFF) + X_W'(col);
          bus.vga_y    <= Y_W'(Y_OFF);
          bus.vga_clr  <= bus.rd_data[0] ? COL_W'(WALL_CLR)
                                         : COL_W'(BG_CLR);
        end
        state == ST_WALL: begin
          if (!col_end) begin
            row          <= row + 1'b1;
            col_bits     <= col_bits >> 1;
            bus.vga_plot <= 1'b1;
            bus.vga_y    <= Y_W'(Y_OFF) + Y_W'(row) + 1'b1;
            bus.vga_clr  <= col_bits[0] ? COL_W'(WALL_CLR)
                                        : COL_W'(BG_CLR);
          end else if (!last_col) begin
            state      <= ST_FETCH;
            col        <= col + 1'b1;
            bus.rd_col <= col + 1'b1;
          end else begin
            state <= ST_SPRITE;
          end
        end
        state == ST_ERASE: begin
          if (scan_last) state <= ST_SPRITE;
        end
        state == ST_SPRITE: begin
          if (scan_last) begin
            state      <= ST_DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            prev_x     <= s_x;
            prev_y     <= s_y;
            prev_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (scan_start || scan_step) begin
        bus.vga_plot <= rect_in;
        if (rect_in) begin
          bus.vga_x   <= X_W'(X_OFF) + X_W'(fx);
          bus.vga_y   <= Y_W'(Y_OFF) + Y_W'(fy);
          bus.vga_clr <= rclr;
        end
      end
    end
  end

endmodule
